// File: rtl/bth_uart_pkg.sv
// Shared definitions for the bth UART receiver: FSM state codes, parity modes
// and the helpers used to derive the baud divider and the expected parity bit.
package bth_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b010,
        ST_PARITY = 3'b011,
        ST_STOP   = 3'b100,
        ST_BREAK  = 3'b101
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Rounded integer division: clocks per oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        calc_div = (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

    // Zero-extending the payload to 9 bits leaves its XOR unchanged.
    function automatic logic parity_bit(input int mode, input logic [8:0] data);
        parity_bit = (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/bth_rx_fifo.sv
// Receive FIFO: power-of-two depth, extra pointer bit separates full from empty,
// head word read combinationally from storage.
module bth_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_wr = wr_en && (!full || w_do_rd);
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            // NOTE: storage is reset so the head word reads zero out of reset.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/bth_uart_rx.sv
// Oversampling UART receiver: synchronizer, tick divider, framing FSM with
// optional parity and break detection, feeding a small receive FIFO.
module bth_uart_rx
    import bth_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [2:0]           ste
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_sync;
    logic                   r_rx_prev;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [OS_W-1:0]        r_os_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic                   r_stop_cnt;
    logic                   r_stop_bad;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic w_rx, w_fall, w_start, w_tick, w_sample;
    logic w_wr, w_perr, w_ferr, w_stop_low, w_full, w_empty;

    assign w_rx    = r_sync[1];
    assign w_fall  = r_rx_prev && !w_rx;
    assign w_start = (r_state == ST_IDLE) && w_fall;
    assign w_tick  = (r_div_cnt == DIV_LAST);
    // Start bit is sampled at its middle; later bits one full bit-time apart.
    assign w_sample = w_tick &&
        (r_os_cnt == ((r_state == ST_START) ? HALF_LAST : OS_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_div_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments make the flops shift one stage per clock.
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx;
            r_div_cnt <= (w_start || w_tick) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_stop_bad <= 1'b0;
            r_shift    <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_os_cnt   <= '0;
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
                r_stop_bad <= 1'b0;
            end else if (w_tick) begin
                r_os_cnt <= w_sample ? '0 : r_os_cnt + OS_W'(1);
            end
            if (w_sample && r_state == ST_DATA) begin
                r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (w_sample && r_state == ST_STOP) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
                r_stop_bad <= r_stop_bad | ~w_rx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        w_stop_low  = r_stop_bad | ~w_rx;
        case (r_state)
            ST_IDLE:   if (w_fall) w_state_nxt = ST_START;
            ST_START:  if (w_sample) w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
            ST_DATA:
                if (w_sample && r_bit_cnt == BIT_LAST)
                    w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY:
                if (w_sample) begin
                    w_perr      = (w_rx != parity_bit(PARITY, 9'(r_shift)));
                    w_state_nxt = ST_STOP;
                end
            ST_STOP:
                if (w_sample && r_stop_cnt == STOP_LAST) begin
                    if (w_stop_low) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = (r_shift == '0) ? ST_BREAK : ST_IDLE;
                    end else begin
                        w_wr        = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            ST_BREAK:  if (w_rx) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= w_perr;
            r_frame_err  <= w_ferr;
            r_overrun    <= w_wr && w_full && !rd_en;
        end
    end

    bth_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr),
        .wr_data (r_shift),
        .rd_en   (rd_en),
        .rd_data (data_out),
        .empty   (w_empty),
        .full    (w_full)
    );

    assign data_valid = !w_empty;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign ste        = r_state;

endmodule

// File: tb/tb_bth_uart_rx.sv
// Scoreboard bench for bth_uart_rx: stimulus queues expected words and error
// pulses, a monitor pops and compares them as the receiver presents them.
module tb_bth_uart_rx;
    import bth_uart_pkg::*;

    localparam int OS     = 16;
    localparam int DIV_T  = 4;
    localparam int BAUD   = 9600;
    localparam int CLK_HZ = BAUD * OS * DIV_T;
    localparam int BIT    = OS * DIV_T;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, overrun;
    logic [2:0] ste;

    logic       rx_p = 1'b1;
    logic       p_rd_en = 1'b0;
    logic [7:0] p_data_out;
    logic       p_data_valid, p_parity_err, p_frame_err, p_overrun;
    logic [2:0] p_ste;

    always #10 clk = ~clk;

    bth_uart_rx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en),
        .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .ste(ste)
    );

    bth_uart_rx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_par (
        .clk(clk), .reset(reset), .rx(rx_p), .rd_en(p_rd_en),
        .data_out(p_data_out), .data_valid(p_data_valid), .parity_err(p_parity_err),
        .frame_err(p_frame_err), .overrun(p_overrun), .ste(p_ste)
    );

    typedef enum logic [1:0] {EV_PERR, EV_FERR, EV_OVR} ev_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         p_perr_cnt = 0;
    int         p_other_cnt = 0;
    bit         auto_rd = 1'b0;
    bit         force_rd = 1'b0;
    ev_t        ev_q[$];
    logic [7:0] data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic got_event(input ev_t ev);
        if (ev_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got event %0d, expected none", ev);
        end else begin
            check("event_kind", 32'(ev), 32'(ev_q.pop_front()));
        end
    endtask

    // Monitor: reads the FIFO when allowed and checks every pulse it sees.
    initial forever begin
        @(negedge clk);
        rd_en = (auto_rd && data_valid) || force_rd;
        if (parity_err) got_event(EV_PERR);
        if (frame_err)  got_event(EV_FERR);
        if (overrun)    got_event(EV_OVR);
        if (rd_en && data_valid) begin
            if (data_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_data: got 0x%0h, expected no word", data_out);
            end else begin
                check("data_out", 32'(data_out), 32'(data_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (p_parity_err) p_perr_cnt++;
        if (p_frame_err || p_overrun) p_other_cnt++;
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx   = v;
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit (par < 0: none).
    task automatic send_head(input bit sel, input logic [7:0] d, input int par);
        drive(sel, 1'b0);
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_clks(BIT);
        end
        if (par >= 0) begin
            drive(sel, par[0]);
            wait_clks(BIT);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input int par, input logic stop_v);
        send_head(sel, d, par);
        drive(sel, stop_v);
        wait_clks(BIT);
        drive(sel, 1'b1);
        wait_clks(2 * BIT);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && data_q.size() != 0; i++) wait_clks(1);
        check("drain_left", 32'(data_q.size()), 0);
    endtask

    initial begin
        logic [7:0] b;

        wait_clks(5);
        check("reset_ste", 32'(ste), 32'(ST_IDLE));
        check("reset_valid", 32'(data_valid), 0);
        check("reset_data", 32'(data_out), 0);
        check("reset_perr", 32'(parity_err), 0);
        check("reset_ferr", 32'(frame_err), 0);
        check("reset_ovr", 32'(overrun), 0);
        check("reset_p_valid", 32'(p_data_valid), 0);
        reset = 1'b0;
        wait_clks(4);

        // 0x31 8N1 with data_valid timing around the mid-stop sample
        data_q.push_back(8'h31);
        send_head(1'b0, 8'h31, -1);
        drive(1'b0, 1'b1);
        wait_clks(28);
        check("valid_before_stop_mid", 32'(data_valid), 0);
        wait_clks(12);
        check("valid_after_stop_mid", 32'(data_valid), 1);
        check("head_31", 32'(data_out), 32'h31);
        wait_clks(2 * BIT);
        auto_rd = 1'b1;
        drain();
        auto_rd = 1'b0;

        // Stop bit low on a non-zero payload
        ev_q.push_back(EV_FERR);
        send_frame(1'b0, 8'h55, -1, 1'b0);
        check("valid_after_ferr", 32'(data_valid), 0);
        check("ste_after_ferr", 32'(ste), 32'(ST_IDLE));

        // Break: line held low well past a full frame
        ev_q.push_back(EV_FERR);
        drive(1'b0, 1'b0);
        wait_clks(13 * BIT);
        check("ste_break", 32'(ste), 32'(ST_BREAK));
        wait_clks(BIT);
        check("ste_break_held", 32'(ste), 32'(ST_BREAK));
        drive(1'b0, 1'b1);
        wait_clks(6);
        check("ste_break_exit", 32'(ste), 32'(ST_IDLE));
        check("valid_after_break", 32'(data_valid), 0);
        wait_clks(BIT);

        // Glitch of three ticks
        drive(1'b0, 1'b0);
        wait_clks(3 * DIV_T);
        drive(1'b0, 1'b1);
        wait_clks(2);
        check("ste_glitch_start", 32'(ste), 32'(ST_START));
        wait_clks(BIT);
        check("ste_glitch_idle", 32'(ste), 32'(ST_IDLE));
        check("valid_after_glitch", 32'(data_valid), 0);

        // Five frames into a four-deep FIFO with no reads
        for (int i = 0; i < 5; i++) begin
            b = 8'(8'h41 + i);
            if (i < 4) data_q.push_back(b);
            else       ev_q.push_back(EV_OVR);
            send_frame(1'b0, b, -1, 1'b1);
        end
        check("valid_full", 32'(data_valid), 1);
        check("head_after_overrun", 32'(data_out), 32'h41);
        auto_rd = 1'b1;
        drain();
        wait_clks(2);
        check("valid_drained", 32'(data_valid), 0);

        // Reads while empty must not move the pointers
        force_rd = 1'b1;
        wait_clks(4);
        force_rd = 1'b0;
        wait_clks(2);
        check("valid_empty_read", 32'(data_valid), 0);
        data_q.push_back(8'h5A);
        send_frame(1'b0, 8'h5A, -1, 1'b1);
        drain();

        // Even parity: 0x33 has four ones, so parity bit 1 is a mismatch
        send_frame(1'b1, 8'h33, 1, 1'b1);
        check("p_perr_count", 32'(p_perr_cnt), 1);
        check("p_other_count", 32'(p_other_cnt), 0);
        check("p_valid", 32'(p_data_valid), 1);
        check("p_head_33", 32'(p_data_out), 32'h33);
        p_rd_en = 1'b1;
        wait_clks(1);
        p_rd_en = 1'b0;
        wait_clks(1);
        check("p_valid_popped", 32'(p_data_valid), 0);
        send_frame(1'b1, 8'h35, 0, 1'b1);
        check("p_perr_count_good", 32'(p_perr_cnt), 1);
        check("p_head_35", 32'(p_data_out), 32'h35);

        // Reset during data bit 4 of 0x39, then 0x32
        b = 8'h39;
        drive(1'b0, 1'b0);
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, b[i]);
            wait_clks(BIT);
        end
        drive(1'b0, b[4]);
        wait_clks(BIT / 2);
        check("ste_before_reset", 32'(ste), 32'(ST_DATA));
        reset = 1'b1;
        wait_clks(3);
        check("ste_in_reset", 32'(ste), 32'(ST_IDLE));
        reset = 1'b0;
        wait_clks(2 * BIT);
        check("ste_after_reset", 32'(ste), 32'(ST_IDLE));
        check("valid_after_reset", 32'(data_valid), 0);
        data_q.push_back(8'h32);
        send_frame(1'b0, 8'h32, -1, 1'b1);
        drain();

        wait_clks(4);
        check("events_left", 32'(ev_q.size()), 0);
        check("p_ste_final", 32'(p_ste), 32'(ST_IDLE));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
